// File: rtl/drm_activator_pkg.sv
// Shared lane layouts, state encoding and constants for the multi-channel DRM activator bridge.
package drm_activator_pkg;

    localparam int LANE_W = 8;

    localparam int RSP_DAT_BIT  = 0;
    localparam int RSP_STA_BIT  = 1;
    localparam int RSP_INTR_BIT = 2;
    localparam int RSP_ACK_BIT  = 3;

    // ACK/INTR are events; every other response bit is a level
    localparam logic [LANE_W-1:0] RESP_EVENT_MASK =
        (LANE_W'(1) << RSP_ACK_BIT) | (LANE_W'(1) << RSP_INTR_BIT);

    typedef struct packed {
        logic [1:0] rsvd;
        logic       cs;
        logic       cyc;
        logic [1:0] adr;
        logic       we;
        logic       dat;
    } cmd_lane_t;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       ack;
        logic       intr;
        logic       sta;
        logic       dat;
    } resp_lane_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_t;

endpackage

// File: rtl/drm_activator_lane.sv
// One activator channel: holds the last accepted command lane and samples the response,
// accumulating ACK/INTR until the word carrying them has been loaded for transmission.
module drm_activator_lane
    import drm_activator_pkg::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic [7:0] cmd_byte,
    input  logic       clear_events,
    input  logic       ack,
    input  logic       sta,
    input  logic       intr,
    input  logic       dat_o,
    output logic       cs,
    output logic       cyc,
    output logic [1:0] adr,
    output logic       we,
    output logic       dat_i,
    output resp_lane_t resp
);

    cmd_lane_t  cmd_in;
    logic       unused_rsvd;
    logic       cs_reg;
    logic       cyc_reg;
    logic [1:0] adr_reg;
    logic       we_reg;
    logic       dat_reg;
    resp_lane_t resp_reg;
    resp_lane_t resp_next;

    assign cmd_in      = cmd_lane_t'(cmd_byte);
    assign unused_rsvd = ^cmd_in.rsvd;

    always_ff @(posedge clk) begin
        if (srst) begin
            cs_reg  <= 1'b0;
            cyc_reg <= 1'b0;
            adr_reg <= 2'b00;
            we_reg  <= 1'b0;
            dat_reg <= 1'b0;
        end else if (load && ENABLE) begin
            cs_reg  <= cmd_in.cs;
            cyc_reg <= cmd_in.cyc;
            adr_reg <= cmd_in.adr;
            we_reg  <= cmd_in.we;
            dat_reg <= cmd_in.dat;
        end
    end

    // A fresh event arriving on the load cycle survives the clear
    always_comb begin
        resp_next      = '0;
        resp_next.ack  = ENABLE & (ack  | (resp_reg.ack  & ~clear_events));
        resp_next.intr = ENABLE & (intr | (resp_reg.intr & ~clear_events));
        resp_next.sta  = ENABLE & sta;
        resp_next.dat  = ENABLE & dat_o;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            resp_reg <= '0;
        end else begin
            resp_reg <= resp_next;
        end
    end

    assign cs    = cs_reg;
    assign cyc   = cyc_reg;
    assign adr   = adr_reg;
    assign we    = we_reg;
    assign dat_i = dat_reg;
    assign resp  = resp_reg;

endmodule

// File: rtl/drm_activator_bridge_mc.sv
// AXI4-Stream bridge between the DRM Controller and NUM_CHANNELS activator cores:
// command unpack, change/keep-alive driven response packing, and core power-on reset.
module drm_activator_bridge_mc
    import drm_activator_pkg::*;
#(
    parameter int                      NUM_CHANNELS     = 4,
    parameter int                      POR_DURATION     = 16,
    parameter int                      KEEPALIVE_CYCLES = 1024,
    parameter logic [NUM_CHANNELS-1:0] CHANNEL_MASK     = '1
) (
    input  logic                         drm_aclk,
    input  logic                         drm_arst,
    input  logic                         drm_to_uip_tvalid,
    output logic                         drm_to_uip_tready,
    input  logic [8*NUM_CHANNELS-1:0]    drm_to_uip_tdata,
    output logic                         uip_to_drm_tvalid,
    input  logic                         uip_to_drm_tready,
    output logic [8*NUM_CHANNELS-1:0]    uip_to_drm_tdata,
    output logic [NUM_CHANNELS-1:0]      act_bus_cs,
    output logic [NUM_CHANNELS-1:0]      act_bus_cyc,
    output logic [NUM_CHANNELS-1:0]      act_bus_we,
    output logic [NUM_CHANNELS-1:0]      act_bus_dat_i,
    output logic [2*NUM_CHANNELS-1:0]    act_bus_adr,
    input  logic [NUM_CHANNELS-1:0]      act_bus_ack,
    input  logic [NUM_CHANNELS-1:0]      act_bus_sta,
    input  logic [NUM_CHANNELS-1:0]      act_bus_intr,
    input  logic [NUM_CHANNELS-1:0]      act_bus_dat_o,
    input  logic [NUM_CHANNELS-1:0]      act_code_ready,
    output logic                         act_core_rst,
    output logic                         all_codes_ready
);

    localparam int WORD_W = LANE_W * NUM_CHANNELS;
    localparam int POR_W  = $clog2(POR_DURATION + 1);
    localparam int KA_W   = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
    localparam logic [KA_W-1:0] KA_MAX =
        (KEEPALIVE_CYCLES > 0) ? KA_W'(KEEPALIVE_CYCLES - 1) : '0;
    localparam logic [WORD_W-1:0] LEVEL_MASK = {NUM_CHANNELS{~RESP_EVENT_MASK}};

    logic [POR_W-1:0]  por_cnt_reg;
    logic              core_rst_reg;
    logic              cmd_load;
    logic              resp_hs;
    logic              load_word;
    logic              keepalive_hit;
    logic [WORD_W-1:0] resp_q;
    logic [WORD_W-1:0] tdata_reg;
    logic [WORD_W-1:0] last_sent_reg;
    logic [KA_W-1:0]   ka_cnt_reg;
    logic [KA_W-1:0]   ka_cnt_next;
    logic              codes_ready_reg;
    out_state_t        state_reg;
    out_state_t        state_next;
    resp_lane_t        lane_resp [NUM_CHANNELS];

    always_ff @(posedge drm_aclk) begin
        if (drm_arst) begin
            por_cnt_reg  <= '0;
            core_rst_reg <= 1'b1;
        end else if (core_rst_reg) begin
            if (por_cnt_reg == POR_W'(POR_DURATION - 1)) begin
                core_rst_reg <= 1'b0;
            end else begin
                por_cnt_reg <= por_cnt_reg + 1'b1;
            end
        end
    end

    assign drm_to_uip_tready = ~drm_arst & ~core_rst_reg;
    assign cmd_load          = drm_to_uip_tvalid & drm_to_uip_tready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
            drm_activator_lane #(
                .ENABLE (CHANNEL_MASK[gi])
            ) u_lane (
                .clk          (drm_aclk),
                .srst         (drm_arst),
                .load         (cmd_load),
                .cmd_byte     (drm_to_uip_tdata[LANE_W*gi +: LANE_W]),
                .clear_events (load_word),
                .ack          (act_bus_ack[gi]),
                .sta          (act_bus_sta[gi]),
                .intr         (act_bus_intr[gi]),
                .dat_o        (act_bus_dat_o[gi]),
                .cs           (act_bus_cs[gi]),
                .cyc          (act_bus_cyc[gi]),
                .adr          (act_bus_adr[2*gi +: 2]),
                .we           (act_bus_we[gi]),
                .dat_i        (act_bus_dat_i[gi]),
                .resp         (lane_resp[gi])
            );
            assign resp_q[LANE_W*gi +: LANE_W] = lane_resp[gi];
        end
    endgenerate

    assign uip_to_drm_tvalid = (state_reg == SEND);
    assign resp_hs           = uip_to_drm_tvalid & uip_to_drm_tready;

    always_comb begin
        ka_cnt_next = ka_cnt_reg;
        if (resp_hs) begin
            ka_cnt_next = '0;
        end else if (ka_cnt_reg != KA_MAX) begin
            ka_cnt_next = ka_cnt_reg + 1'b1;
        end
    end

    assign keepalive_hit = (KEEPALIVE_CYCLES != 0) && (ka_cnt_next == KA_MAX);

    // last_sent keeps only level bits so a consumed event pulse is not resent as a change
    always_comb begin
        state_next = state_reg;
        load_word  = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((resp_q != last_sent_reg) || keepalive_hit) begin
                    state_next = SEND;
                    load_word  = 1'b1;
                end
            end
            SEND: begin
                if (resp_hs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge drm_aclk) begin
        if (drm_arst) begin
            state_reg       <= IDLE;
            tdata_reg       <= '0;
            last_sent_reg   <= '0;
            ka_cnt_reg      <= '0;
            codes_ready_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ka_cnt_reg      <= ka_cnt_next;
            codes_ready_reg <= &(act_code_ready | ~CHANNEL_MASK);
            if (load_word) begin
                tdata_reg     <= resp_q;
                last_sent_reg <= resp_q & LEVEL_MASK;
            end
        end
    end

    assign uip_to_drm_tdata = tdata_reg;
    assign act_core_rst     = core_rst_reg;
    assign all_codes_ready  = codes_ready_reg;

endmodule

// File: tb/tb_drm_activator_bridge_mc.sv
// Bench for drm_activator_bridge_mc: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the bridge.
module tb_drm_activator_bridge_mc;

    localparam int N   = 4;
    localparam int POR = 16;
    localparam int KA  = 8;
    localparam logic [N-1:0] MASK = 4'b0111;

    logic           clk = 1'b0;
    logic           drm_arst;
    logic           drm_to_uip_tvalid;
    logic           drm_to_uip_tready;
    logic [8*N-1:0] drm_to_uip_tdata;
    logic           uip_to_drm_tvalid;
    logic           uip_to_drm_tready;
    logic [8*N-1:0] uip_to_drm_tdata;
    logic [N-1:0]   act_bus_cs, act_bus_cyc, act_bus_we, act_bus_dat_i;
    logic [2*N-1:0] act_bus_adr;
    logic [N-1:0]   act_bus_ack, act_bus_sta, act_bus_intr, act_bus_dat_o, act_code_ready;
    logic           act_core_rst;
    logic           all_codes_ready;

    always #5 clk = ~clk;

    drm_activator_bridge_mc #(
        .NUM_CHANNELS     (N),
        .POR_DURATION     (POR),
        .KEEPALIVE_CYCLES (KA),
        .CHANNEL_MASK     (MASK)
    ) dut (
        .drm_aclk          (clk),
        .drm_arst          (drm_arst),
        .drm_to_uip_tvalid (drm_to_uip_tvalid),
        .drm_to_uip_tready (drm_to_uip_tready),
        .drm_to_uip_tdata  (drm_to_uip_tdata),
        .uip_to_drm_tvalid (uip_to_drm_tvalid),
        .uip_to_drm_tready (uip_to_drm_tready),
        .uip_to_drm_tdata  (uip_to_drm_tdata),
        .act_bus_cs        (act_bus_cs),
        .act_bus_cyc       (act_bus_cyc),
        .act_bus_we        (act_bus_we),
        .act_bus_dat_i     (act_bus_dat_i),
        .act_bus_adr       (act_bus_adr),
        .act_bus_ack       (act_bus_ack),
        .act_bus_sta       (act_bus_sta),
        .act_bus_intr      (act_bus_intr),
        .act_bus_dat_o     (act_bus_dat_o),
        .act_code_ready    (act_code_ready),
        .act_core_rst      (act_core_rst),
        .all_codes_ready   (all_codes_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what each lane holds, what the controller should currently see
    bit [5:0]  m_cmd  [N];
    bit [3:0]  m_resp [N];
    bit        m_valid;
    bit [31:0] m_data;
    bit [31:0] m_last;
    int        m_since;
    int        m_rel;
    bit        m_core_rst = 1'b1;
    bit        m_acr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] resp_word();
        bit [31:0] w;
        w = '0;
        for (int c = 0; c < N; c++) w[8*c +: 8] = {4'b0000, m_resp[c]};
        return w;
    endfunction

    task automatic model_update();
        bit        tready_exp;
        bit        hs;
        bit        load;
        bit [31:0] cur;
        tready_exp = !drm_arst && !m_core_rst;
        if (drm_arst) begin
            for (int c = 0; c < N; c++) begin
                m_cmd[c]  = '0;
                m_resp[c] = '0;
            end
            m_valid = 0; m_data = '0; m_last = '0; m_since = 0;
            m_rel = 0; m_core_rst = 1; m_acr = 0;
        end else begin
            m_rel++;
            m_core_rst = (m_rel < POR);
            if (drm_to_uip_tvalid && tready_exp)
                for (int c = 0; c < N; c++)
                    m_cmd[c] = MASK[c] ? drm_to_uip_tdata[8*c +: 6] : 6'd0;
            cur  = resp_word();
            hs   = m_valid && uip_to_drm_tready;
            load = 0;
            if (m_valid) begin
                if (hs) begin
                    $display("[TB] t=%0t response word 0x%08h accepted", $time, m_data);
                    m_valid = 0;
                end
            end else if (cur != m_last || (KA != 0 && m_since + 1 >= KA - 1)) begin
                load    = 1;
                m_valid = 1;
                m_data  = cur;
                m_last  = cur & ~32'h0C0C0C0C;
            end
            m_since = hs ? 0 : m_since + 1;
            for (int c = 0; c < N; c++) begin
                if (MASK[c])
                    m_resp[c] = {act_bus_ack[c] | (m_resp[c][3] & !load),
                                 act_bus_intr[c] | (m_resp[c][2] & !load),
                                 act_bus_sta[c], act_bus_dat_o[c]};
                else
                    m_resp[c] = '0;
            end
            m_acr = &(act_code_ready | ~MASK);
        end
    endtask

    task automatic compare_all();
        logic [N-1:0]   e_cs, e_cyc, e_we, e_dat;
        logic [2*N-1:0] e_adr;
        for (int c = 0; c < N; c++) begin
            e_cs[c]        = m_cmd[c][5];
            e_cyc[c]       = m_cmd[c][4];
            e_adr[2*c +: 2] = m_cmd[c][3:2];
            e_we[c]        = m_cmd[c][1];
            e_dat[c]       = m_cmd[c][0];
        end
        check_val("tready", drm_to_uip_tready, !drm_arst && !m_core_rst);
        check_val("core_rst", act_core_rst, m_core_rst);
        check_val("codes_ready", all_codes_ready, m_acr);
        check_val("tvalid", uip_to_drm_tvalid, m_valid);
        check_val("tdata", uip_to_drm_tdata, m_data);
        check_val("bus_cs", act_bus_cs, e_cs);
        check_val("bus_cyc", act_bus_cyc, e_cyc);
        check_val("bus_adr", act_bus_adr, e_adr);
        check_val("bus_we", act_bus_we, e_we);
        check_val("bus_dat_i", act_bus_dat_i, e_dat);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (uip_to_drm_tvalid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check_val(tag, uip_to_drm_tvalid, 1'b1);
    endtask

    task automatic count_por(input string tag);
        int hi = 0;
        while (act_core_rst === 1'b1 && hi < 40) begin
            hi++;
            step();
        end
        check_val(tag, hi, POR);
    endtask

    initial begin
        int words;
        drm_arst = 1; drm_to_uip_tvalid = 0; drm_to_uip_tdata = '0; uip_to_drm_tready = 1;
        act_bus_ack = '0; act_bus_sta = '0; act_bus_intr = '0; act_bus_dat_o = '0;
        act_code_ready = '0;
        repeat (3) step();
        check_val("reset_core_rst", act_core_rst, 1'b1);

        // POR length and command-ready release
        drm_arst = 0;
        count_por("t1_por_len");
        check_val("t1_tready", drm_to_uip_tready, 1'b1);

        // Command on lane 2, then held
        drm_to_uip_tvalid = 1; drm_to_uip_tdata = 32'h003D_0000;
        step();
        drm_to_uip_tvalid = 0; drm_to_uip_tdata = $urandom;
        check_val("t2_cs", act_bus_cs[2], 1'b1);
        check_val("t2_cyc", act_bus_cyc[2], 1'b1);
        check_val("t2_adr", act_bus_adr[5:4], 2'd3);
        check_val("t2_we", act_bus_we[2], 1'b0);
        check_val("t2_dat", act_bus_dat_i[2], 1'b1);
        repeat (10) step();
        check_val("t2_hold_cs", act_bus_cs[2], 1'b1);
        check_val("t2_hold_adr", act_bus_adr[5:4], 2'd3);

        // ACK pulse under back-pressure: one word, held, not resent
        wait_valid(20, "t3_sync");
        act_bus_ack = 4'b0010;
        step();
        act_bus_ack = '0; uip_to_drm_tready = 0;
        step();
        check_val("t3_valid", uip_to_drm_tvalid, 1'b1);
        check_val("t3_word", uip_to_drm_tdata, 32'h0000_0800);
        repeat (20) step();
        check_val("t3_held", uip_to_drm_tdata, 32'h0000_0800);
        uip_to_drm_tready = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t3_no_resend", uip_to_drm_tvalid, 1'b0);
        end

        // Keep-alive with static responses
        act_bus_sta = 4'b0101; act_bus_dat_o = 4'b0011;
        repeat (20) step();
        words = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (uip_to_drm_tvalid) begin
                words++;
                check_val("t4_data", uip_to_drm_tdata, 32'h0002_0103);
            end
        end
        check_val("t4_words", words, 8);

        // All inputs high with lane 3 disabled
        act_bus_ack = '1; act_bus_intr = '1; act_bus_sta = '1; act_bus_dat_o = '1;
        act_code_ready = '1;
        drm_to_uip_tvalid = 1; drm_to_uip_tdata = 32'hFFFF_FFFF;
        step();
        drm_to_uip_tvalid = 0;
        step();
        check_val("t5_cs3", act_bus_cs[3], 1'b0);
        check_val("t5_cs2", act_bus_cs[2], 1'b1);
        check_val("t5_acr_all", all_codes_ready, 1'b1);
        act_code_ready = 4'b1000;
        step();
        check_val("t5_acr_dis", all_codes_ready, 1'b0);
        act_code_ready = 4'b0111;
        step();
        check_val("t5_acr_en", all_codes_ready, 1'b1);
        wait_valid(20, "t5_word_seen");
        check_val("t5_word", uip_to_drm_tdata, 32'h000F_0F0F);

        // Reset while a word is stalled
        uip_to_drm_tready = 0;
        wait_valid(10, "t6_pending");
        drm_arst = 1;
        act_bus_ack = '0; act_bus_intr = '0; act_bus_sta = '0; act_bus_dat_o = '0;
        act_code_ready = '0;
        step();
        check_val("t6_drop", uip_to_drm_tvalid, 1'b0);
        step();
        drm_arst = 0;
        count_por("t6_por_len");
        wait_valid(30, "t6_keepalive");
        check_val("t6_no_stale", uip_to_drm_tdata, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drm_arst          = ($urandom_range(0, 299) == 0);
            drm_to_uip_tvalid = $urandom_range(0, 1);
            drm_to_uip_tdata  = $urandom;
            uip_to_drm_tready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) begin
                act_bus_ack[c]  = ($urandom_range(0, 7) == 0);
                act_bus_intr[c] = ($urandom_range(0, 11) == 0);
            end
            if ($urandom_range(0, 15) == 0) act_bus_sta    = N'($urandom);
            if ($urandom_range(0, 15) == 0) act_bus_dat_o  = N'($urandom);
            if ($urandom_range(0, 7) == 0)  act_code_ready = N'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
